core_sequencer: RTL and testbench

- Multi-cycle control FSM that sequences the single-issue datapath: ALU, register file, program counter, instruction and data memories.
- Steps each instruction through fetch, decode, execute, optional memory access and writeback.
- Handles variable-latency memories with a req/ready handshake and enforces a memory-wait timeout.
- Sits between the combinational control unit and the datapath enables; also counts retired instructions.

---
 rtl/core_sequencer_pkg.sv | 53 +++++
 rtl/core_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_core_sequencer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_sequencer_pkg.sv
// Shared types and constants for the multi-cycle core sequencer.
package core_sequencer_pkg;

  // Sequencer states; the encoding is visible on state_out for debug.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALT      = 3'd6
  } state_e;

  // Reason the core stopped; FAULT_NONE also covers a SYSTEM halt.
  typedef enum logic [1:0] {
    FAULT_NONE    = 2'd0,
    FAULT_ILLEGAL = 2'd1,
    FAULT_TIMEOUT = 2'd2
  } fault_e;

  // Control-unit bits captured in EXECUTE for use by later states.
  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic pc_src;
  } ControlSignals;

  // RV32I major opcodes.
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // True for opcodes the datapath can execute (SYSTEM is handled separately).
  function automatic logic is_legal_opcode(input logic [6:0] op);
    logic legal;
    case (op)
      OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
      default:                           legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM: fetch, decode, execute, memory, writeback, with
// req/ready memory handshakes, a wait timeout and a retired-instruction count.
//
// Handshake: a request (imem_req_out / dmem_req_out, plus dmem_we_out) is
// raised on entry to FETCH / MEMORY and held stable every cycle until the
// matching ready input is sampled high at a rising edge; that edge completes
// the transfer and the request drops in the following cycle.
module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 run_en_in,
  input  logic [6:0]           opcode_in,
  input  logic                 ctrl_mem_read_in,
  input  logic                 ctrl_mem_write_in,
  input  logic                 ctrl_reg_write_in,
  input  logic                 branch_taken_in,
  output logic                 imem_req_out,
  input  logic                 imem_ready_in,
  output logic                 dmem_req_out,
  output logic                 dmem_we_out,
  input  logic                 dmem_ready_in,
  output logic                 ir_write_en_out,
  output logic                 pc_write_en_out,
  output logic                 pc_src_out,
  output logic                 reg_write_en_out,
  output logic [2:0]           state_out,
  output logic                 halted_out,
  output logic [1:0]           fault_out,
  output logic [CNT_WIDTH-1:0] retired_out
);

  // Wide enough to hold MEM_TIMEOUT itself.
  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 2);

  state_e              r_state;
  state_e              w_state_next;
  ControlSignals       r_ctrl;
  fault_e              r_fault;
  fault_e              w_fault_code;
  logic                w_fault_set;
  logic                w_retire;
  logic [CNT_WIDTH-1:0] r_retired;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic                w_wait_low;
  logic                w_enter_wait;
  logic                w_timeout;

  // Memory wait bookkeeping: a ready seen in the limit cycle still wins.
  assign w_wait_low   = ((r_state == ST_FETCH)  && !imem_ready_in) ||
                        ((r_state == ST_MEMORY) && !dmem_ready_in);
  assign w_enter_wait = ((w_state_next == ST_FETCH) || (w_state_next == ST_MEMORY)) &&
                        (w_state_next != r_state);
  assign w_timeout    = (MEM_TIMEOUT != 0) && (r_wait_cnt == WAIT_W'(MEM_TIMEOUT));

  assign state_out   = r_state;
  assign halted_out  = (r_state == ST_HALT);
  assign fault_out   = r_fault;
  assign retired_out = r_retired;

  // State, latched control bits, fault cause, wait and retire counters.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_ctrl     <= '0;
      r_fault    <= FAULT_NONE;
      r_retired  <= '0;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_EXECUTE) begin
        r_ctrl <= '{mem_read:  ctrl_mem_read_in,
                    mem_write: ctrl_mem_write_in,
                    reg_write: ctrl_reg_write_in,
                    pc_src:    branch_taken_in};
      end
      if (w_fault_set) r_fault <= w_fault_code;
      if (w_retire)    r_retired <= r_retired + CNT_WIDTH'(1);
      if (w_enter_wait) begin
        r_wait_cnt <= '0;
      end else if (w_wait_low && (MEM_TIMEOUT != 0)) begin
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end
    end
  end

  // Next-state logic and per-state datapath strobes.
  always_comb begin
    w_state_next     = r_state;
    w_fault_set      = 1'b0;
    w_fault_code     = FAULT_NONE;
    w_retire         = 1'b0;
    imem_req_out     = 1'b0;
    ir_write_en_out  = 1'b0;
    dmem_req_out     = 1'b0;
    dmem_we_out      = 1'b0;
    pc_write_en_out  = 1'b0;
    pc_src_out       = 1'b0;
    reg_write_en_out = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (run_en_in) w_state_next = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req_out = 1'b1;
        if (imem_ready_in) begin
          ir_write_en_out = 1'b1;
          w_state_next    = ST_DECODE;
        end else if (w_timeout) begin
          w_state_next = ST_HALT;
          w_fault_set  = 1'b1;
          w_fault_code = FAULT_TIMEOUT;
        end
      end
      ST_DECODE: begin
        if (opcode_in == OP_SYSTEM) begin
          w_state_next = ST_HALT;
          w_fault_set  = 1'b1;
          w_fault_code = FAULT_NONE;
        end else if (!is_legal_opcode(opcode_in)) begin
          w_state_next = ST_HALT;
          w_fault_set  = 1'b1;
          w_fault_code = FAULT_ILLEGAL;
        end else begin
          w_state_next = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        // The latch happens at this edge, so a branch retire uses the live input.
        if (ctrl_mem_read_in && ctrl_mem_write_in) begin
          w_state_next = ST_HALT;
          w_fault_set  = 1'b1;
          w_fault_code = FAULT_ILLEGAL;
        end else if (ctrl_mem_read_in || ctrl_mem_write_in) begin
          w_state_next = ST_MEMORY;
        end else if (ctrl_reg_write_in) begin
          w_state_next = ST_WRITEBACK;
        end else begin
          w_retire   = 1'b1;
          pc_src_out = branch_taken_in;
        end
      end
      ST_MEMORY: begin
        dmem_req_out = 1'b1;
        dmem_we_out  = r_ctrl.mem_write;
        if (dmem_ready_in) begin
          if (r_ctrl.mem_read) begin
            w_state_next = ST_WRITEBACK;
          end else begin
            w_retire   = 1'b1;
            pc_src_out = r_ctrl.pc_src;
          end
        end else if (w_timeout) begin
          w_state_next = ST_HALT;
          w_fault_set  = 1'b1;
          w_fault_code = FAULT_TIMEOUT;
        end
      end
      ST_WRITEBACK: begin
        reg_write_en_out = 1'b1;
        w_retire         = 1'b1;
        pc_src_out       = r_ctrl.pc_src;
      end
      ST_HALT: begin
        w_state_next = ST_HALT;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    // Retire closes the instruction; run_en_in decides whether to continue.
    if (w_retire) begin
      pc_write_en_out = 1'b1;
      w_state_next    = run_en_in ? ST_FETCH : ST_IDLE;
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: one instruction class per block,
// expected states and strobes written out by hand.
module tb_core_sequencer;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        run_en_in;
  logic [6:0]  opcode_in;
  logic        ctrl_mem_read_in;
  logic        ctrl_mem_write_in;
  logic        ctrl_reg_write_in;
  logic        branch_taken_in;
  logic        imem_req_out;
  logic        imem_ready_in;
  logic        dmem_req_out;
  logic        dmem_we_out;
  logic        dmem_ready_in;
  logic        ir_write_en_out;
  logic        pc_write_en_out;
  logic        pc_src_out;
  logic        reg_write_en_out;
  logic [2:0]  state_out;
  logic        halted_out;
  logic [1:0]  fault_out;
  logic [31:0] retired_out;
  logic [6:0]  strobes;

  int n_checks = 0;
  int n_errors = 0;

  // Strobe vector: imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_src, reg_we
  assign strobes = {imem_req_out, ir_write_en_out, dmem_req_out, dmem_we_out,
                    pc_write_en_out, pc_src_out, reg_write_en_out};

  core_sequencer #(.MEM_TIMEOUT(16), .CNT_WIDTH(32)) dut (
    .clk_in            (clk_in),
    .reset             (reset),
    .run_en_in         (run_en_in),
    .opcode_in         (opcode_in),
    .ctrl_mem_read_in  (ctrl_mem_read_in),
    .ctrl_mem_write_in (ctrl_mem_write_in),
    .ctrl_reg_write_in (ctrl_reg_write_in),
    .branch_taken_in   (branch_taken_in),
    .imem_req_out      (imem_req_out),
    .imem_ready_in     (imem_ready_in),
    .dmem_req_out      (dmem_req_out),
    .dmem_we_out       (dmem_we_out),
    .dmem_ready_in     (dmem_ready_in),
    .ir_write_en_out   (ir_write_en_out),
    .pc_write_en_out   (pc_write_en_out),
    .pc_src_out        (pc_src_out),
    .reg_write_en_out  (reg_write_en_out),
    .state_out         (state_out),
    .halted_out        (halted_out),
    .fault_out         (fault_out),
    .retired_out       (retired_out)
  );

  // Clock
  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled at the following falling edge.
  task automatic step();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic set_ctrl(input logic [6:0] op, input logic rd, input logic wr, input logic rw);
    opcode_in         = op;
    ctrl_mem_read_in  = rd;
    ctrl_mem_write_in = wr;
    ctrl_reg_write_in = rw;
  endtask

  task automatic do_reset();
    run_en_in = 1'b0;
    reset     = 1'b0;
    step();
    reset     = 1'b1;
  endtask

  initial begin
    reset = 1'b0; run_en_in = 1'b0; branch_taken_in = 1'b0;
    imem_ready_in = 1'b0; dmem_ready_in = 1'b0;
    set_ctrl(7'b0000000, 1'b0, 1'b0, 1'b0);
    @(negedge clk_in);
    step(); step();
    check_eq("rst_state",   state_out, 3'd0);
    check_eq("rst_strobes", strobes, 7'b0000000);
    check_eq("rst_halted",  halted_out, 1'b0);
    check_eq("rst_fault",   fault_out, 2'd0);
    check_eq("rst_retired", retired_out, 32'd0);
    reset = 1'b1;

    // R-type, zero-wait imem: retire in WRITEBACK
    imem_ready_in = 1'b1;
    set_ctrl(7'b0110011, 1'b0, 1'b0, 1'b1);
    run_en_in = 1'b1;
    step();
    check_eq("r_fetch_state",   state_out, 3'd1);
    check_eq("r_fetch_strobes", strobes, 7'b1100000);
    run_en_in = 1'b0;
    step();
    check_eq("r_decode_state",   state_out, 3'd2);
    check_eq("r_decode_strobes", strobes, 7'b0000000);
    step();
    check_eq("r_exec_state",   state_out, 3'd3);
    check_eq("r_exec_strobes", strobes, 7'b0000000);
    step();
    check_eq("r_wb_state",   state_out, 3'd5);
    check_eq("r_wb_strobes", strobes, 7'b0000101);
    step();
    check_eq("r_idle_state", state_out, 3'd0);
    check_eq("r_retired",    retired_out, 32'd1);

    // Load with dmem ready delayed 3 cycles
    set_ctrl(7'b0000011, 1'b1, 1'b0, 1'b1);
    dmem_ready_in = 1'b0;
    run_en_in = 1'b1;
    step();
    run_en_in = 1'b0;
    step(); step();
    check_eq("ld_exec_state", state_out, 3'd3);
    step();
    for (int i = 0; i < 4; i++) begin
      check_eq("ld_mem_state",   state_out, 3'd4);
      check_eq("ld_mem_strobes", strobes, 7'b0010000);
      if (i == 3) dmem_ready_in = 1'b1;
      step();
    end
    check_eq("ld_wb_state",   state_out, 3'd5);
    check_eq("ld_wb_strobes", strobes, 7'b0000101);
    dmem_ready_in = 1'b0;
    step();
    check_eq("ld_idle_state", state_out, 3'd0);
    check_eq("ld_retired",    retired_out, 32'd2);

    // Taken branch: EXECUTE is the retire cycle
    set_ctrl(7'b1100011, 1'b0, 1'b0, 1'b0);
    run_en_in = 1'b1;
    step();
    run_en_in = 1'b0;
    step();
    branch_taken_in = 1'b1;
    step();
    check_eq("br_exec_state",   state_out, 3'd3);
    check_eq("br_exec_strobes", strobes, 7'b0000110);
    branch_taken_in = 1'b0;
    step();
    check_eq("br_idle_state",   state_out, 3'd0);
    check_eq("br_idle_strobes", strobes, 7'b0000000);
    check_eq("br_retired",      retired_out, 32'd3);

    // Store, run_en dropped while in MEMORY: completes then IDLE
    set_ctrl(7'b0100011, 1'b0, 1'b1, 1'b0);
    run_en_in = 1'b1;
    step(); step(); step(); step();
    check_eq("st_mem_state",   state_out, 3'd4);
    check_eq("st_mem_strobes", strobes, 7'b0011000);
    run_en_in = 1'b0;
    step();
    check_eq("st_mem_hold", state_out, 3'd4);
    dmem_ready_in = 1'b1;
    #1;
    check_eq("st_retire_strobes", strobes, 7'b0011100);
    step();
    dmem_ready_in = 1'b0;
    check_eq("st_idle_state", state_out, 3'd0);
    check_eq("st_retired",    retired_out, 32'd4);

    // imem ready arriving in the cycle the count reaches 16 still completes
    imem_ready_in = 1'b0;
    set_ctrl(7'b0110011, 1'b0, 1'b0, 1'b1);
    run_en_in = 1'b1;
    step();
    run_en_in = 1'b0;
    repeat (16) step();
    check_eq("tb_edge_state",   state_out, 3'd1);
    check_eq("tb_edge_strobes", strobes, 7'b1000000);
    imem_ready_in = 1'b1;
    step();
    check_eq("tb_edge_decode", state_out, 3'd2);
    step(); step(); step();
    check_eq("tb_edge_idle",    state_out, 3'd0);
    check_eq("tb_edge_retired", retired_out, 32'd5);

    // imem ready stuck low: timeout fault
    imem_ready_in = 1'b0;
    run_en_in = 1'b1;
    step();
    run_en_in = 1'b0;
    repeat (16) step();
    check_eq("to_last_wait", state_out, 3'd1);
    step();
    check_eq("to_state",   state_out, 3'd6);
    check_eq("to_halted",  halted_out, 1'b1);
    check_eq("to_fault",   fault_out, 2'd2);
    check_eq("to_strobes", strobes, 7'b0000000);
    run_en_in = 1'b1; imem_ready_in = 1'b1;
    step(); step();
    check_eq("to_sticky_state", state_out, 3'd6);
    check_eq("to_sticky_fault", fault_out, 2'd2);
    do_reset();
    check_eq("to_rst_state",   state_out, 3'd0);
    check_eq("to_rst_fault",   fault_out, 2'd0);
    check_eq("to_rst_retired", retired_out, 32'd0);

    // Illegal opcode 1111111
    set_ctrl(7'b1111111, 1'b0, 1'b0, 1'b0);
    run_en_in = 1'b1;
    step(); step(); step();
    check_eq("ill_state",  state_out, 3'd6);
    check_eq("ill_fault",  fault_out, 2'd1);
    check_eq("ill_halted", halted_out, 1'b1);
    do_reset();

    // SYSTEM opcode: halt with no fault
    set_ctrl(7'b1110011, 1'b0, 1'b0, 1'b0);
    run_en_in = 1'b1;
    step(); step(); step();
    check_eq("sys_state",  state_out, 3'd6);
    check_eq("sys_fault",  fault_out, 2'd0);
    check_eq("sys_halted", halted_out, 1'b1);
    do_reset();

    // Load and store both asserted: illegal fault from EXECUTE
    set_ctrl(7'b0000011, 1'b1, 1'b1, 1'b0);
    run_en_in = 1'b1;
    step(); step(); step(); step();
    check_eq("rw_state", state_out, 3'd6);
    check_eq("rw_fault", fault_out, 2'd1);
    do_reset();

    // Back-to-back issue, then reset in the middle of a load's MEMORY
    set_ctrl(7'b0110011, 1'b0, 1'b0, 1'b1);
    dmem_ready_in = 1'b0;
    run_en_in = 1'b1;
    step(); step(); step(); step(); step();
    check_eq("b2b_state",   state_out, 3'd1);
    check_eq("b2b_retired", retired_out, 32'd1);
    set_ctrl(7'b0000011, 1'b1, 1'b0, 1'b1);
    step(); step(); step();
    check_eq("rm_mem_state", state_out, 3'd4);
    reset = 1'b0;
    step();
    check_eq("rm_state",   state_out, 3'd0);
    check_eq("rm_strobes", strobes, 7'b0000000);
    check_eq("rm_retired", retired_out, 32'd0);
    check_eq("rm_halted",  halted_out, 1'b0);
    check_eq("rm_fault",   fault_out, 2'd0);
    run_en_in = 1'b0;
    reset = 1'b1;
    step();
    check_eq("rm_after_state",   state_out, 3'd0);
    check_eq("rm_after_strobes", strobes, 7'b0000000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
